// File: rtl/cache_def.sv
// Shared cache/memory interface types plus the SRAM line controller's constants and state encoding.
package cache_def;

  localparam int SRAM_AW    = 18;
  localparam int LINE_BEATS = 8;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_ACC,
    WR_GAP,
    DONE
  } sram_state_e;

endpackage

// File: rtl/sram_line_ctrl.sv
// Turns one 128-bit cache-line request into eight 16-bit accesses on an asynchronous SRAM
// and returns the assembled line (reads) or a completion pulse (writes).
module sram_line_ctrl
  import cache_def::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  mem_req_type        mem_req_i,
  output mem_data_type       mem_result_o,
  output logic               busy_o,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  localparam int             WCW       = $clog2(WAIT_CYCLES) + 1;
  localparam int             LINE_AW   = SRAM_AW - 3;
  localparam logic [WCW-1:0] WC_LAST   = WCW'(WAIT_CYCLES - 1);
  localparam logic [2:0]     LAST_BEAT = 3'(LINE_BEATS - 1);

  sram_state_e        r_state;
  sram_state_e        w_state_next;
  logic [LINE_AW-1:0] r_line;
  logic [127:0]       r_wdata;
  logic [127:0]       r_rdbuf;
  logic [127:0]       r_result;
  logic [2:0]         r_beat;
  logic [WCW-1:0]     r_wcnt;

  logic [6:0]         w_bit_ofs;
  logic [15:0]        w_wr_word;
  logic [127:0]       w_rd_line;
  logic               w_acc_last;
  logic               w_dq_oe;
  logic               w_unused;

  // Byte offset within the line and the bits above the 512 KB window are don't-care.
  assign w_unused = ^{mem_req_i.addr[31:SRAM_AW+1], mem_req_i.addr[3:0]};

  assign w_bit_ofs  = {r_beat, 4'b0000};
  assign w_wr_word  = r_wdata[w_bit_ofs +: 16];
  assign w_acc_last = (r_wcnt == WC_LAST);
  assign SRAM_ADDR  = {r_line, r_beat};
  assign SRAM_DQ    = w_dq_oe ? w_wr_word : 16'bz;

  always_comb begin
    w_rd_line                  = r_rdbuf;
    w_rd_line[w_bit_ofs +: 16] = SRAM_DQ;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_line   <= '0;
      r_wdata  <= '0;
      r_rdbuf  <= '0;
      r_result <= '0;
      r_beat   <= '0;
      r_wcnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (mem_req_i.valid) begin
            r_line  <= mem_req_i.addr[SRAM_AW:4];
            r_wdata <= mem_req_i.data;
            r_beat  <= '0;
            r_wcnt  <= '0;
          end
        end
        RD_ACC: begin
          if (w_acc_last) begin
            r_wcnt  <= '0;
            r_rdbuf <= w_rd_line;
            // The final beat goes straight to the result so it is valid in the DONE cycle.
            if (r_beat == LAST_BEAT) r_result <= w_rd_line;
            else                     r_beat   <= r_beat + 3'd1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        WR_ACC: begin
          if (w_acc_last) r_wcnt <= '0;
          else            r_wcnt <= r_wcnt + 1'b1;
        end
        WR_GAP: begin
          if (r_beat != LAST_BEAT) r_beat <= r_beat + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next       = r_state;
    SRAM_CE_N          = 1'b1;
    SRAM_OE_N          = 1'b1;
    SRAM_WE_N          = 1'b1;
    SRAM_LB_N          = 1'b1;
    SRAM_UB_N          = 1'b1;
    w_dq_oe            = 1'b0;
    busy_o             = 1'b1;
    mem_result_o.ready = 1'b0;
    mem_result_o.data  = r_result;
    case (r_state)
      IDLE: begin
        busy_o = mem_req_i.valid && !rst_i;
        if (mem_req_i.valid) w_state_next = mem_req_i.rw ? WR_ACC : RD_ACC;
      end
      RD_ACC: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_UB_N = 1'b0;
        if (w_acc_last && r_beat == LAST_BEAT) w_state_next = DONE;
      end
      WR_ACC: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_UB_N = 1'b0;
        w_dq_oe   = 1'b1;
        if (w_acc_last) w_state_next = WR_GAP;
      end
      WR_GAP: begin
        // WE_N high with address and data still held: write hold time.
        SRAM_CE_N    = 1'b0;
        SRAM_LB_N    = 1'b0;
        SRAM_UB_N    = 1'b0;
        w_dq_oe      = 1'b1;
        w_state_next = (r_beat == LAST_BEAT) ? DONE : WR_ACC;
      end
      DONE: begin
        mem_result_o.ready = 1'b1;
        w_state_next       = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Scoreboard bench for sram_line_ctrl: behavioural SRAM, line-level reference model,
// directed scenarios followed by randomized traffic.
module tb_sram_line_ctrl;
  import cache_def::*;

  localparam int W        = 2;
  localparam int N_RANDOM = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  mem_req_type  req;
  mem_data_type res;
  logic         busy;
  logic [17:0]  sram_addr;
  wire  [15:0]  sram_dq;
  logic         ce_n, oe_n, we_n, lb_n, ub_n;

  sram_line_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mem_req_i    (req),
    .mem_result_o (res),
    .busy_o       (busy),
    .SRAM_ADDR    (sram_addr),
    .SRAM_DQ      (sram_dq),
    .SRAM_CE_N    (ce_n),
    .SRAM_OE_N    (oe_n),
    .SRAM_WE_N    (we_n),
    .SRAM_LB_N    (lb_n),
    .SRAM_UB_N    (ub_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives reads while selected and output-enabled, latches on WE_N rise.
  logic [15:0] sram_mem [0:(1<<18)-1];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'hzzzz;
  always @(posedge we_n) if (!rst && !ce_n) sram_mem[sram_addr] = sram_dq;

  typedef struct {
    logic         rw;
    logic [14:0]  line;
    logic [127:0] wdata;
    logic [127:0] exp_data;
  } sb_entry_t;

  sb_entry_t    sb_q[$];
  logic [127:0] line_mem [int];
  logic [127:0] last_read = '0;
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  int           t_acc = 0;
  int           we_run = 0;
  int           pulses = 0;
  bit           dut_idle = 1'b1;
  bit           done_seen = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: untouched SRAM word k holds k+0x100; written lines come back verbatim.
  function automatic logic [127:0] model_line(input int ln);
    logic [127:0] v;
    if (line_mem.exists(ln)) return line_mem[ln];
    for (int b = 0; b < 8; b++) v[16*b +: 16] = 16'((ln * 8 + b + 256) & 32'hffff);
    return v;
  endfunction

  // Acceptance tracker: mirrors the L2-side view of when the controller takes a request.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
    end else if (done_seen) begin
      done_seen = 1'b0;
      dut_idle  = 1'b1;
    end else if (dut_idle && req.valid) begin
      dut_idle = 1'b0;
      t_acc    = cyc;
    end
  end

  // Monitor: bus-protocol checks every cycle, scoreboard pop on each ready pulse.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!rst) begin
      if (!oe_n) begin
        chk("oe_low_we_high", we_n, 1);
        chk("busy_during_read", busy, 1);
        if (sb_q.size() > 0)
          chk("rd_addr", sram_addr, {sb_q[0].line, 3'((cyc - t_acc) / W)});
      end
      if (!we_n) begin
        we_run++;
      end else if (we_run > 0) begin
        chk("we_width", we_run, W);
        if (sb_q.size() > 0 && pulses < 8) begin
          chk("wr_addr", sram_addr, {sb_q[0].line, 3'(pulses)});
          chk("wr_dq_hold", sram_dq, sb_q[0].wdata[16*pulses +: 16]);
        end
        pulses++;
        we_run = 0;
      end
      if (res.ready) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_ready: got ready=1 with no request outstanding, required ready=0");
        end else begin
          e = sb_q.pop_front();
          if (e.rw) chk("wr_ack_data", res.data, e.exp_data);
          else      chk("rd_data", res.data, e.exp_data);
          chk("latency", cyc - t_acc, e.rw ? 8 * (W + 1) : 8 * W);
          chk("we_pulses", pulses, e.rw ? 8 : 0);
          chk("busy_at_ready", busy, 1);
          $display("txn %0s line=%h data=%h lat=%0d", e.rw ? "WR" : "RD", e.line, res.data, cyc - t_acc);
        end
        pulses    = 0;
        done_seen = 1'b1;
      end
    end
  end

  task automatic start_req(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    sb_entry_t e;
    int        ln;
    ln      = int'(addr[18:4]);
    e.rw    = rw;
    e.line  = addr[18:4];
    e.wdata = data;
    if (rw) begin
      e.exp_data   = last_read;
      line_mem[ln] = data;
    end else begin
      e.exp_data = model_line(ln);
      last_read  = e.exp_data;
    end
    sb_q.push_back(e);
    req.addr  = addr;
    req.data  = data;
    req.rw    = rw;
    req.valid = 1'b1;
  endtask

  task automatic wait_ready(input bit keep_valid);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!res.ready && n < 200);
    if (!res.ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got no ready in %0d cycles, required ready within %0d", n, 8 * (W + 1) + 1);
      sb_q.delete();
    end
    if (!keep_valid) req.valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req.valid = 1'b0;
    #1;
    chk("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1f);
    chk("rst_ready", res.ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res.data, 0);
    chk("rst_addr", sram_addr, 0);
    sb_q.delete();
    dut_idle  = 1'b1;
    done_seen = 1'b0;
    we_run    = 0;
    pulses    = 0;
    last_read = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_gap();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit           kept;
    bit           keep;
    logic [31:0]  addr;
    logic [127:0] data;

    req = '0;
    for (int k = 0; k < (1 << 18); k++) sram_mem[k] = 16'(k + 256);
    #1 rst = 1'b1;
    do_reset();

    // Directed: plain read, plain write, write->read back-to-back with valid held.
    idle_gap(); start_req(1'b0, 32'h0000_0040, '0); wait_ready(1'b0);
    idle_gap(); start_req(1'b1, 32'h0000_0010, 128'h7777_6666_5555_4444_3333_2222_1111_0000); wait_ready(1'b0);
    idle_gap(); start_req(1'b1, 32'h0000_0030, 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe); wait_ready(1'b1);
    start_req(1'b0, 32'h0000_0030, '0); wait_ready(1'b0);
    idle_gap(); start_req(1'b0, 32'h0000_0010, '0); wait_ready(1'b0);

    // Reset landing in beat 3 of a read; no ready may follow, then a clean read.
    idle_gap(); start_req(1'b0, 32'h0000_0100, '0);
    repeat (3 * W + 1) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    #1;
    start_req(1'b0, 32'h0000_0100, '0); wait_ready(1'b0);

    // Aliasing above the 512 KB window.
    idle_gap(); start_req(1'b1, 32'h0008_0020, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100); wait_ready(1'b0);
    idle_gap(); start_req(1'b0, 32'h0000_0020, '0); wait_ready(1'b0);

    kept = 1'b0;
    for (int i = 0; i < N_RANDOM; i++) begin
      keep = (i != N_RANDOM - 1) && ($urandom_range(0, 3) == 0);
      if (!kept) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
      end
      addr        = $urandom;
      addr[18:4]  = 15'($urandom_range(0, 7) * 1237 + 2);
      data        = {$urandom, $urandom, $urandom, $urandom};
      start_req(1'($urandom_range(0, 1)), addr, data);
      wait_ready(keep);
      kept = keep;
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
